// File: rtl/sound_mixer_if.sv
// Bundle of sound_mixer signals: register/channel inputs, PCM sample outputs and the I2S pins.
// master = APU/register side, slave = the mixer itself.
interface sound_mixer_if;
    logic        sound_enable;
    logic [3:0]  ch1_level;
    logic [3:0]  ch2_level;
    logic [3:0]  ch3_level;
    logic [3:0]  ch4_level;
    logic [7:0]  panning;
    logic [2:0]  left_vol;
    logic [2:0]  right_vol;
    logic [15:0] left;
    logic [15:0] right;
    logic        sample_valid;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_sdata;

    modport master (
        output sound_enable, ch1_level, ch2_level, ch3_level, ch4_level,
        output panning, left_vol, right_vol,
        input  left, right, sample_valid, i2s_bclk, i2s_lrck, i2s_sdata
    );

    modport slave (
        input  sound_enable, ch1_level, ch2_level, ch3_level, ch4_level,
        input  panning, left_vol, right_vol,
        output left, right, sample_valid, i2s_bclk, i2s_lrck, i2s_sdata
    );
endinterface

// File: rtl/sound_mixer.sv
// Four-channel stereo mixer: pans and scales channel levels once per 64-cycle frame into 16-bit PCM.
// Optional I2S serializer enabled by defining SOUND_MIXER_I2S_EN; otherwise the i2s_* pins are tied low.
module sound_mixer (
    input  logic         clk,
    input  logic         rst,
    sound_mixer_if.slave bus
);

    logic [5:0]  fc_r;
    logic [15:0] left_r;
    logic [15:0] right_r;
    logic        sample_valid_r;
    logic [15:0] levels_s;
    logic [15:0] left_word_s;
    logic [15:0] right_word_s;
    logic        load_s;

    // Sum of the levels whose route bit is set; levels packed {ch4, ch3, ch2, ch1}.
    function automatic logic [5:0] side_sum(input logic [3:0] mask, input logic [15:0] lv);
        logic [5:0] s;
        s = 6'd0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                s = s + {2'b00, lv[i*4 +: 4]};
            end else begin
                s = s;
            end
        end
        return s;
    endfunction

    // Scale by gain vol+1 and place the 9-bit result below a zero sign bit.
    function automatic logic [15:0] mix_word(input logic [5:0] sum, input logic [2:0] vol,
                                             input logic en);
        logic [8:0] prod;
        prod = 9'(sum) * (9'(vol) + 9'd1);
        return en ? {1'b0, prod, 6'd0} : 16'd0;
    endfunction

    assign levels_s = {bus.ch4_level, bus.ch3_level, bus.ch2_level, bus.ch1_level};
    assign load_s   = (fc_r == 6'd63);

    // Per-side sample words from the current inputs; only consumed on the load edge.
    always_comb begin
        left_word_s  = 16'd0;
        right_word_s = 16'd0;
        left_word_s  = mix_word(side_sum(bus.panning[7:4], levels_s), bus.left_vol, bus.sound_enable);
        right_word_s = mix_word(side_sum(bus.panning[3:0], levels_s), bus.right_vol, bus.sound_enable);
    end

    // Frame counter and parallel sample registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fc_r           <= 6'd0;
            left_r         <= 16'd0;
            right_r        <= 16'd0;
            sample_valid_r <= 1'b0;
        end else begin
            fc_r           <= fc_r + 6'd1;
            sample_valid_r <= load_s;
            if (load_s) begin
                left_r  <= left_word_s;
                right_r <= right_word_s;
            end
        end
    end

    assign bus.left         = left_r;
    assign bus.right        = right_r;
    assign bus.sample_valid = sample_valid_r;

`ifdef SOUND_MIXER_I2S_EN
    logic [31:0] shift_r;
    logic        sdata_r;

    // MSB-first shifter updated as bclk falls; the load edge emits the last bit of the
    // previous frame (right[0]) while capturing the new {left, right} word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= 32'd0;
            sdata_r <= 1'b0;
        end else if (load_s) begin
            sdata_r <= shift_r[31];
            shift_r <= {left_word_s, right_word_s};
        end else if (fc_r[0]) begin
            sdata_r <= shift_r[31];
            shift_r <= {shift_r[30:0], 1'b0};
        end
    end

    assign bus.i2s_bclk  = fc_r[0];
    assign bus.i2s_lrck  = fc_r[5];
    assign bus.i2s_sdata = sdata_r;
`else
    assign bus.i2s_bclk  = 1'b0;
    assign bus.i2s_lrck  = 1'b0;
    assign bus.i2s_sdata = 1'b0;
`endif

endmodule
